// File: rtl/led_matrix_pkg.sv
// Shared constants, FSM states and the bit-plane select helper for the LED matrix driver.
package led_matrix_pkg;

  // Default panel geometry and colour depth.
  localparam int COLS  = 64;
  localparam int ROWS  = 24;
  localparam int BPP   = 4;
  localparam int ROW_W = 5;
  localparam int COL_W = $clog2(COLS);

  // Widest colour depth the plane-select helper accepts.
  localparam int MAX_BPP = 16;
  localparam int PIX_MAX_W = 6 * MAX_BPP;

  // Field indices inside a pixel word; a field starts at bit (index * bpp).
  localparam int FIELD_R0 = 0;
  localparam int FIELD_G0 = 1;
  localparam int FIELD_B0 = 2;
  localparam int FIELD_R1 = 3;
  localparam int FIELD_G1 = 4;
  localparam int FIELD_B1 = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } line_state_t;

  // Bit `pwm` of each of the six colour fields, ordered {b1,g1,r1,b0,g0,r0}.
  // An out-of-range plane yields all zeros.
  function automatic logic [5:0] plane_select(input logic [PIX_MAX_W-1:0] word,
                                              input logic [3:0] pwm,
                                              input int bpp);
    logic [5:0] bits;
    logic [6:0] idx;
    bits = '0;
    idx  = '0;
    if (int'(pwm) < bpp) begin
      for (int f = FIELD_R0; f <= FIELD_B1; f++) begin
        idx     = 7'(f * bpp + int'(pwm));
        bits[f] = word[idx];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/led_line_shifter.sv
// Reads one display line from frame RAM and shifts one bit-plane of it into the
// panel's top/bottom RGB shift registers, two system cycles per column.
module led_line_shifter
  import led_matrix_pkg::*;
#(
  parameter int COLS  = led_matrix_pkg::COLS,
  parameter int BPP   = led_matrix_pkg::BPP,
  parameter int ROW_W = led_matrix_pkg::ROW_W,
  parameter int COL_W = $clog2(COLS)
) (
  input  logic                   clk_25MHz,
  input  logic                   rst,
  input  logic                   next_line_begin,
  input  logic [ROW_W-1:0]       next_line_addr,
  input  logic [3:0]             next_line_pwm,
  output logic                   next_line_done,
  output logic                   ram_rd_en,
  output logic [ROW_W+COL_W-1:0] ram_addr,
  input  logic [6*BPP-1:0]       ram_rdata,
  output logic                   sclk,
  output logic [5:0]             rgb
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  line_state_t      state_reg;
  logic [ROW_W-1:0] row_reg;
  logic [3:0]       pwm_reg;
  logic [COL_W-1:0] col_reg;
  logic             shifting_reg;
  logic             sclk_reg;
  logic             done_reg;
  logic             rd_en_reg;
  logic [ROW_W+COL_W-1:0] addr_reg;

  // Line FSM: every output is set on the edge that enters the state it belongs to,
  // so the registered outputs line up with the state of the current cycle.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      row_reg      <= '0;
      pwm_reg      <= '0;
      col_reg      <= '0;
      shifting_reg <= 1'b0;
      sclk_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rd_en_reg    <= 1'b0;
      addr_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg  <= 1'b0;
          rd_en_reg <= 1'b0;
          if (next_line_begin) begin
            row_reg   <= next_line_addr;
            pwm_reg   <= next_line_pwm;
            col_reg   <= '0;
            rd_en_reg <= 1'b1;
            addr_reg  <= {next_line_addr, {COL_W{1'b0}}};
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Column 0 data arrives from RAM as we enter the first low phase.
          rd_en_reg    <= 1'b0;
          shifting_reg <= 1'b1;
          sclk_reg     <= 1'b0;
          state_reg    <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          // Prefetch the next column during the high phase; RAM output holds
          // until the following edge, so rgb stays stable across the rising sclk.
          sclk_reg  <= 1'b1;
          state_reg <= S_SHIFT_HI;
          if (col_reg != LAST_COL) begin
            rd_en_reg <= 1'b1;
            addr_reg  <= {row_reg, col_reg + COL_W'(1)};
          end
        end
        S_SHIFT_HI: begin
          sclk_reg  <= 1'b0;
          rd_en_reg <= 1'b0;
          if (col_reg != LAST_COL) begin
            col_reg   <= col_reg + COL_W'(1);
            state_reg <= S_SHIFT_LO;
          end else begin
            shifting_reg <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          shifting_reg <= 1'b0;
          sclk_reg     <= 1'b0;
          done_reg     <= 1'b0;
          rd_en_reg    <= 1'b0;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  // Serial data is the selected plane of the RAM word, forced low outside shifting.
  always_comb begin
    rgb = '0;
    if (shifting_reg) begin
      rgb = plane_select(PIX_MAX_W'(ram_rdata), pwm_reg, BPP);
    end
  end

  assign sclk           = sclk_reg;
  assign next_line_done = done_reg;
  assign ram_rd_en      = rd_en_reg;
  assign ram_addr       = addr_reg;

endmodule

// File: tb/tb_led_line_shifter.sv
// Scoreboard bench for led_line_shifter with COLS=4, BPP=4: the stimulus pushes
// expected reads, shift edges and done pulses; a negedge monitor pops and compares.
module tb_led_line_shifter;

  localparam int COLS  = 4;
  localparam int BPP   = 4;
  localparam int ROW_W = 5;
  localparam int COL_W = 2;

  logic             clk_25MHz = 1'b0;
  logic             rst;
  logic             next_line_begin;
  logic [ROW_W-1:0] next_line_addr;
  logic [3:0]       next_line_pwm;
  logic             next_line_done;
  logic             ram_rd_en;
  logic [ROW_W+COL_W-1:0] ram_addr;
  logic [6*BPP-1:0] ram_rdata = '0;
  logic             sclk;
  logic [5:0]       rgb;

  always #20 clk_25MHz = ~clk_25MHz;

  led_line_shifter #(.COLS(COLS), .BPP(BPP), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk_25MHz      (clk_25MHz),
    .rst            (rst),
    .next_line_begin(next_line_begin),
    .next_line_addr (next_line_addr),
    .next_line_pwm  (next_line_pwm),
    .next_line_done (next_line_done),
    .ram_rd_en      (ram_rd_en),
    .ram_addr       (ram_addr),
    .ram_rdata      (ram_rdata),
    .sclk           (sclk),
    .rgb            (rgb)
  );

  // Frame RAM model: one-cycle read latency, output holds between reads.
  logic [23:0] mem [0:127];
  always @(posedge clk_25MHz) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  typedef struct { int cyc; logic [6:0] addr; } rd_exp_t;
  typedef struct { int cyc; logic [5:0] rgb; } sh_exp_t;
  rd_exp_t rd_q[$];
  sh_exp_t sh_q[$];
  int      done_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops an expectation whenever the DUT shows a read, a rising sclk or done.
  logic       prev_sclk = 1'b0;
  logic [5:0] prev_rgb = '0;
  always @(negedge clk_25MHz) begin : monitor
    rd_exp_t re;
    sh_exp_t se;
    int      dc;
    if (ram_rd_en === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'(ram_rd_en), 0);
      else begin
        re = rd_q.pop_front();
        check("rd_cycle", cyc, re.cyc);
        check("rd_addr", 32'(ram_addr), 32'(re.addr));
      end
    end
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (sh_q.size() == 0) check("sclk_unexpected", 32'(sclk), 0);
      else begin
        se = sh_q.pop_front();
        check("sclk_rise_cycle", cyc, se.cyc);
        check("rgb_lo", 32'(prev_rgb), 32'(se.rgb));
        check("rgb_hi", 32'(rgb), 32'(se.rgb));
      end
    end
    if (next_line_done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", 32'(next_line_done), 0);
      else begin
        dc = done_q.pop_front();
        check("done_cycle", cyc, dc);
        check("done_rgb", 32'(rgb), 0);
        check("done_sclk", 32'(sclk), 0);
      end
    end
    prev_sclk <= sclk;
    prev_rgb  <= rgb;
  end

  task automatic check_quiet(input string tag);
    check({tag, "_sclk"}, 32'(sclk), 0);
    check({tag, "_rgb"}, 32'(rgb), 0);
    check({tag, "_done"}, 32'(next_line_done), 0);
    check({tag, "_rd_en"}, 32'(ram_rd_en), 0);
    check({tag, "_addr"}, 32'(ram_addr), 0);
  endtask

  // One line starting in the current cycle. exp_rgb holds column k at [6k+:6].
  // busy_at > 0: extra begin (row 9) in that relative cycle.
  // rst_at > 0: reset in that relative cycle; the line is cut short there.
  task automatic run_line(input logic [4:0] row, input logic [3:0] pwm,
                          input logic [23:0] exp_rgb, input int busy_at, input int rst_at);
    int c0;
    int last;
    rd_exp_t re;
    sh_exp_t se;
    c0   = cyc;
    last = (rst_at > 0) ? rst_at : 2 * COLS + 2;
    re.cyc = c0 + 1;
    re.addr = {row, 2'd0};
    rd_q.push_back(re);
    for (int k = 0; k < COLS; k++) begin
      if (2 * k + 3 <= last) begin
        se.cyc = c0 + 2 * k + 3;
        se.rgb = exp_rgb[6*k +: 6];
        sh_q.push_back(se);
        if (k < COLS - 1) begin
          re.cyc  = c0 + 2 * k + 3;
          re.addr = {row, 2'(k + 1)};
          rd_q.push_back(re);
        end
      end
    end
    if (rst_at == 0) done_q.push_back(c0 + 2 * COLS + 2);
    for (int i = 0; i <= last; i++) begin
      next_line_begin = (i == 0) || (busy_at > 0 && i == busy_at);
      next_line_addr  = (i == 0) ? row : 5'd9;
      next_line_pwm   = (i == 0) ? pwm : 4'd0;
      rst             = (rst_at > 0 && i == rst_at);
      @(posedge clk_25MHz); #1;
    end
    next_line_begin = 1'b0;
    rst = 1'b0;
    if (rst_at > 0) begin
      @(negedge clk_25MHz);
      check_quiet("after_rst");
      @(posedge clk_25MHz); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    next_line_begin = 1'b0;
    next_line_addr = '0;
    next_line_pwm = '0;
    for (int i = 0; i < 128; i++) mem[i] = 24'h0;
    for (int c = 0; c < COLS; c++) begin
      mem[12 + c] = 24'h00000F << (4 * c);  // row 3
      mem[20 + c] = 24'h555555;             // row 5
      mem[24 + c] = 24'hA5A5A5;             // row 6
      mem[36 + c] = 24'hFFFFFF;             // row 9, must never be shifted
    end
    repeat (2) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    check_quiet("reset");
    @(posedge clk_25MHz); #1;
    rst = 1'b0;

    // Full line, one colour field lit per column: r0, g0, b0, r1.
    run_line(5'd3, 4'd0, {6'b001000, 6'b000100, 6'b000010, 6'b000001}, 0, 0);
    // 0x5 per field: planes 0 and 2 set, 1 and 3 clear.
    run_line(5'd5, 4'd0, {4{6'b111111}}, 0, 0);
    run_line(5'd5, 4'd1, {4{6'b000000}}, 0, 0);
    run_line(5'd5, 4'd2, {4{6'b111111}}, 0, 0);
    run_line(5'd5, 4'd3, {4{6'b000000}}, 0, 0);
    // 0xA5A5A5: r0=5 g0=A b0=5 r1=A g1=5 b1=A -> plane 0 is 010101.
    run_line(5'd6, 4'd0, {4{6'b010101}}, 0, 0);
    // Out-of-range plane: all zero, timing unchanged.
    run_line(5'd3, 4'd7, {4{6'b000000}}, 0, 0);
    // Begin while busy is ignored.
    run_line(5'd3, 4'd0, {6'b001000, 6'b000100, 6'b000010, 6'b000001}, 4, 0);
    // Reset mid-line, then a clean line two cycles later.
    run_line(5'd3, 4'd0, {6'b001000, 6'b000100, 6'b000010, 6'b000001}, 0, 6);
    run_line(5'd3, 4'd1, {6'b001000, 6'b000100, 6'b000010, 6'b000001}, 0, 0);

    for (int i = 0; i < 20 && (rd_q.size() + sh_q.size() + done_q.size()) > 0; i++)
      @(posedge clk_25MHz);
    check("rd_q_left", 32'(rd_q.size()), 0);
    check("sclk_q_left", 32'(sh_q.size()), 0);
    check("done_q_left", 32'(done_q.size()), 0);
    repeat (2) @(posedge clk_25MHz);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
